// File: rtl/jstk_spi_responder.sv
// PmodJSTK joystick emulator on the SPI responder side: serves X/Y/buttons on MISO and
// decodes the master's command byte into the two LED outputs.
module jstk_spi_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned NUM_BYTES   = 5
) (
  input  logic       clk,
  input  logic       RST,
  input  logic [9:0] x_pos,
  input  logic [9:0] y_pos,
  input  logic [2:0] buttons,
  input  logic       SS,
  input  logic       SCLK,
  input  logic       MOSI,
  output logic       MISO,
  output logic [1:0] led,
  output logic       xfer_done,
  output logic       frame_err
);

  localparam logic [2:0] NumBytesW = 3'(NUM_BYTES);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e state;

  logic [SYNC_STAGES-1:0] ss_sync, sck_sync, mosi_sync;
  logic                   ss_prev, sck_prev;
  logic                   ss_s, sck_s, mosi_s;
  logic                   ss_fall, ss_rise, sck_rise, sck_fall;

  logic [SYNC_STAGES:0]   flush;
  logic                   armed;

  logic [9:0] snap_x, snap_y;
  logic [2:0] snap_b;
  logic [7:0] tx_sr, rx_sr, cmd;
  logic [2:0] bit_cnt, byte_cnt;
  logic [7:0] next_byte, rx_byte;
  logic       good_frame;

  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign ss_fall  = ss_prev & ~ss_s;
  assign ss_rise  = ~ss_prev & ss_s;
  assign sck_rise = ~sck_prev & sck_s;
  assign sck_fall = sck_prev & ~sck_s;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      ss_sync   <= '1;
      sck_sync  <= '0;
      mosi_sync <= '0;
      ss_prev   <= 1'b1;
      sck_prev  <= 1'b0;
    end else begin
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS};
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCLK};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      ss_prev   <= ss_s;
      sck_prev  <= sck_s;
    end
  end

  // The SS synchronizer resets high, so a pin held low through reset would look like a
  // fresh fall. Frames are only accepted once SS has been seen high after the flush.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      flush <= '0;
      armed <= 1'b0;
    end else begin
      flush <= {flush[SYNC_STAGES-1:0], 1'b1};
      armed <= armed | (flush[SYNC_STAGES] & ss_s);
    end
  end

  // Byte to present after a boundary; byte_cnt has already advanced past the one just sent.
  always_comb begin
    next_byte = 8'h00;
    case (byte_cnt)
      3'd1:    next_byte = {6'b0, snap_x[9:8]};
      3'd2:    next_byte = snap_y[7:0];
      3'd3:    next_byte = {6'b0, snap_y[9:8]};
      3'd4:    next_byte = {5'b0, snap_b};
      default: next_byte = 8'h00;
    endcase
  end

  assign rx_byte    = {rx_sr[6:0], mosi_s};
  assign good_frame = (byte_cnt == NumBytesW) && (bit_cnt == 3'd0);

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state     <= StIdle;
      MISO      <= 1'b0;
      led       <= 2'b00;
      xfer_done <= 1'b0;
      frame_err <= 1'b0;
      snap_x    <= '0;
      snap_y    <= '0;
      snap_b    <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      cmd       <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
    end else begin
      xfer_done <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        StIdle: begin
          MISO <= 1'b0;
          if (ss_fall && armed) begin
            snap_x   <= x_pos;
            snap_y   <= y_pos;
            snap_b   <= buttons;
            tx_sr    <= x_pos[7:0];
            rx_sr    <= '0;
            cmd      <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            state    <= StShift;
          end
        end
        StShift: begin
          MISO <= tx_sr[7];
          // ss_rise takes priority over any coincident SCLK edge
          if (ss_rise) begin
            state <= StIdle;
            MISO  <= 1'b0;
            if (good_frame) begin
              xfer_done <= 1'b1;
              if (cmd[7]) led <= cmd[1:0];
            end else begin
              frame_err <= 1'b1;
            end
          end else if (sck_rise) begin
            rx_sr   <= rx_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (byte_cnt == 3'd0) cmd <= rx_byte;
              if (byte_cnt != 3'd7) byte_cnt <= byte_cnt + 3'd1;
            end
          end else if (sck_fall) begin
            if (bit_cnt == 3'd0) tx_sr <= next_byte;
            else                 tx_sr <= {tx_sr[6:0], 1'b0};
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
